tdc_acq_controller: RTL and testbench

- Sequences one acquisition window on the pulse-pair TDC and classifies the TDC's event reports into per-channel-pair counters.
- Sits between the TDC (START/END codes, 7-bit interval, data-arrived strobe) and the host readout logic.
- Arms on a host start, counts classified events for a programmed number of clk cycles, then streams the counters out over a valid/ready handshake.

---
 rtl/tdc_pkg.sv | 51 +++++
 rtl/tdc_event_sync.sv | 68 ++++++
 rtl/tdc_acq_controller.sv | 182 ++++++++++++++++++
 tb/tb_tdc_acq_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the pulse-pair TDC acquisition path: FSM state encodings,
// result bin indices, TDC edge codes and the event classifier.
package tdc_pkg;

    localparam int INTERVAL_W = 7;

    // FSM states, kept as plain constants for compatibility with older consumers
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_DRAIN   = 2'd2;
    localparam state_t ST_READOUT = 2'd3;

    // Result bin indices
    localparam logic [2:0] BIN_COINC = 3'd0;
    localparam logic [2:0] BIN_P1P1  = 3'd1;
    localparam logic [2:0] BIN_P1P2  = 3'd2;
    localparam logic [2:0] BIN_P2P1  = 3'd3;
    localparam logic [2:0] BIN_P2P2  = 3'd4;
    localparam logic [2:0] BIN_REJ   = 3'd5;

    // TDC START/END codes
    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_P2   = 2'b01;
    localparam logic [1:0] CODE_P1   = 2'b10;
    localparam logic [1:0] CODE_BOTH = 2'b11;

    // Map a START/END pair plus interval onto a result bin. The coincidence bin
    // bypasses the interval filter; an empty window (lo > hi) rejects bins 1-4.
    function automatic logic [2:0] classify(
        input logic [1:0]            code_start,
        input logic [1:0]            code_end,
        input logic [INTERVAL_W-1:0] interval,
        input logic [INTERVAL_W-1:0] lo,
        input logic [INTERVAL_W-1:0] hi
    );
        logic       in_win;
        logic [2:0] bin;
        in_win = (interval >= lo) && (interval <= hi);
        case ({code_start, code_end})
            {CODE_NONE, CODE_BOTH}: bin = BIN_COINC;
            {CODE_P1, CODE_P1}:     bin = in_win ? BIN_P1P1 : BIN_REJ;
            {CODE_P1, CODE_P2}:     bin = in_win ? BIN_P1P2 : BIN_REJ;
            {CODE_P2, CODE_P1}:     bin = in_win ? BIN_P2P1 : BIN_REJ;
            {CODE_P2, CODE_P2}:     bin = in_win ? BIN_P2P2 : BIN_REJ;
            default:                bin = BIN_REJ;
        endcase
        return bin;
    endfunction

endpackage

// File: rtl/tdc_event_sync.sv
// Brings the asynchronous TDC data-arrived level into the clk domain, detects its
// rising edge and captures the TDC report fields on that edge. event_stb is a
// one-cycle pulse aligned with the registered fields; en qualifies capture.
module tdc_event_sync
    import tdc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  tdc_valid,
    input  logic [1:0]            tdc_start,
    input  logic [1:0]            tdc_end,
    input  logic [INTERVAL_W-1:0] tdc_interval,
    output logic                  event_stb,
    output logic [1:0]            ev_start,
    output logic [1:0]            ev_end,
    output logic [INTERVAL_W-1:0] ev_interval
);

    logic                  sync1_q, sync2_q, prev_q;
    logic                  stb_q, stb_d;
    logic [1:0]            start_q, start_d;
    logic [1:0]            end_q, end_d;
    logic [INTERVAL_W-1:0] interval_q, interval_d;
    logic                  rise;

    assign rise = sync2_q & ~prev_q;

    // Capture the report fields on a qualified rising edge; fields are stable then
    always_comb begin
        stb_d      = rise & en;
        start_d    = start_q;
        end_d      = end_q;
        interval_d = interval_q;
        if (stb_d) begin
            start_d    = tdc_start;
            end_d      = tdc_end;
            interval_d = tdc_interval;
        end
    end

    // Synchroniser, edge-history and event register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            stb_q      <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            interval_q <= '0;
        end else begin
            sync1_q    <= tdc_valid;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            stb_q      <= stb_d;
            start_q    <= start_d;
            end_q      <= end_d;
            interval_q <= interval_d;
        end
    end

    assign event_stb   = stb_q;
    assign ev_start    = start_q;
    assign ev_end      = end_q;
    assign ev_interval = interval_q;

endmodule

// File: rtl/tdc_acq_controller.sv
// Runs one acquisition window on the pulse-pair TDC, sorts the TDC event reports
// into saturating per-bin counters, then streams the bins out over valid/ready.
module tdc_acq_controller
    import tdc_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WIN_W    = 24,
    parameter int unsigned NUM_BINS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIN_W-1:0]      window_len,
    input  logic [INTERVAL_W-1:0] interval_lo,
    input  logic [INTERVAL_W-1:0] interval_hi,
    input  logic [1:0]            tdc_start,
    input  logic [1:0]            tdc_end,
    input  logic [INTERVAL_W-1:0] tdc_interval,
    input  logic                  tdc_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2:0]            res_idx,
    output logic [CNT_W-1:0]      res_data,
    output logic                  overflow
);

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [2:0]       LastIdx = 3'(NUM_BINS - 1);

    state_t                state_q, state_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [1:0]            drain_q, drain_d;
    logic [2:0]            idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  cls_valid_q, cls_valid_d;
    logic [2:0]            bin_q, bin_d;
    logic [CNT_W-1:0]      cnt_q [NUM_BINS];
    logic [CNT_W-1:0]      cnt_d [NUM_BINS];

    logic                  event_stb;
    logic [1:0]            ev_start, ev_end;
    logic [INTERVAL_W-1:0] ev_interval;

    // Only edges detected during RUN are captured
    tdc_event_sync u_event_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (state_q == ST_RUN),
        .tdc_valid    (tdc_valid),
        .tdc_start    (tdc_start),
        .tdc_end      (tdc_end),
        .tdc_interval (tdc_interval),
        .event_stb    (event_stb),
        .ev_start     (ev_start),
        .ev_end       (ev_end),
        .ev_interval  (ev_interval)
    );

    // Classification stage; in-flight events are dropped once the FSM leaves the run
    always_comb begin
        cls_valid_d = event_stb && (state_q != ST_IDLE) && !abort;
        bin_d       = classify(ev_start, ev_end, ev_interval, interval_lo, interval_hi);
    end

    // FSM, window/drain timers, readout index and saturating counters
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        drain_d = drain_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    for (int i = 0; i < NUM_BINS; i++) cnt_d[i] = '0;
                    ovf_d = 1'b0;
                    win_d = window_len;
                    idx_d = '0;
                    if (window_len == '0) begin
                        state_d = ST_DRAIN;
                        drain_d = 2'd2;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (win_q <= WIN_W'(1)) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'd2;
                end else begin
                    win_d = win_q - WIN_W'(1);
                end
            end
            ST_DRAIN: begin
                // Three cycles let a last-RUN-cycle edge reach its counter
                if (drain_q == 2'd0) begin
                    state_d = ST_READOUT;
                    idx_d   = '0;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            ST_READOUT: begin
                if (res_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cls_valid_q && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                if (bin_q == 3'(i)) begin
                    if (cnt_q[i] == CntMax) ovf_d = 1'b1;
                    else                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            drain_q     <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cls_valid_q <= 1'b0;
            bin_q       <= '0;
            for (int i = 0; i < NUM_BINS; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            drain_q     <= drain_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            cls_valid_q <= cls_valid_d;
            bin_q       <= bin_d;
            for (int i = 0; i < NUM_BINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Result word mux; zero outside READOUT
    always_comb begin
        res_data = '0;
        if (state_q == ST_READOUT) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                if (idx_q == 3'(i)) res_data = cnt_q[i];
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_READOUT);
    assign res_idx   = idx_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_tdc_acq_controller.sv
// Directed-plus-random bench for tdc_acq_controller, built with 4-bit counters so
// saturation is reachable. Expected bins come from a reference model of the
// classification rules and window timing.
module tb_tdc_acq_controller;

    localparam int CNT_W = 4;
    localparam int WIN_W = 24;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, abort, tdc_valid, res_ready;
    logic [WIN_W-1:0] window_len;
    logic [6:0]       interval_lo, interval_hi, tdc_interval;
    logic [1:0]       tdc_start, tdc_end;
    logic             busy, done, res_valid, overflow;
    logic [2:0]       res_idx;
    logic [CNT_W-1:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Event schedule: drive cycle t (tdc_valid high for cycles t and t+1)
    int         ev_t[$];
    logic [1:0] ev_s[$];
    logic [1:0] ev_e[$];
    int         ev_i[$];

    tdc_acq_controller #(.CNT_W(CNT_W), .WIN_W(WIN_W), .NUM_BINS(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .window_len   (window_len),
        .interval_lo  (interval_lo),
        .interval_hi  (interval_hi),
        .tdc_start    (tdc_start),
        .tdc_end      (tdc_end),
        .tdc_interval (tdc_interval),
        .tdc_valid    (tdc_valid),
        .busy         (busy),
        .done         (done),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_idx      (res_idx),
        .res_data     (res_data),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference bin for one report, straight from the classification table
    function automatic int model_bin(input logic [1:0] s, input logic [1:0] e,
                                     input int iv, input int lo, input int hi);
        bit ok;
        ok = (iv >= lo) && (iv <= hi);
        if (s == 2'b00 && e == 2'b11) return 0;
        if (s == 2'b10 && e == 2'b10) return ok ? 1 : 5;
        if (s == 2'b10 && e == 2'b01) return ok ? 2 : 5;
        if (s == 2'b01 && e == 2'b10) return ok ? 3 : 5;
        if (s == 2'b01 && e == 2'b01) return ok ? 4 : 5;
        return 5;
    endfunction

    task automatic clear_events();
        ev_t.delete(); ev_s.delete(); ev_e.delete(); ev_i.delete();
    endtask

    task automatic add_ev(input int t, input logic [1:0] s, input logic [1:0] e, input int iv);
        ev_t.push_back(t); ev_s.push_back(s); ev_e.push_back(e); ev_i.push_back(iv);
    endtask

    // One full acquisition: start is driven at cycle 2, so RUN occupies cycles
    // 3..n+2, an edge of an event driven at cycle t lands in cycle t+2, and the
    // first result word appears at cycle n+6.
    task automatic do_run(input string name, input int n, input int lo, input int hi,
                          input int rmode);
        int  raw[6];
        int  exp_cnt[6];
        bit  exp_ovf;
        int  acc;
        bit  finished;
        bit  ended;
        exp_ovf  = 0;
        acc      = 0;
        finished = 0;
        ended    = 0;
        for (int b = 0; b < 6; b++) raw[b] = 0;
        for (int k = 0; k < ev_t.size(); k++) begin
            if (ev_t[k] + 2 >= 3 && ev_t[k] + 2 <= n + 2)
                raw[model_bin(ev_s[k], ev_e[k], ev_i[k], lo, hi)]++;
        end
        for (int b = 0; b < 6; b++) begin
            exp_cnt[b] = (raw[b] > CMAX) ? CMAX : raw[b];
            if (raw[b] > CMAX) exp_ovf = 1;
        end
        interval_lo = 7'(lo);
        interval_hi = 7'(hi);
        window_len  = WIN_W'(n);

        for (int c = 0; c < n + 200 && !ended; c++) begin
            if (finished) begin
                check({name, " done pulse"}, int'(done), 1);
                check({name, " busy after done"}, int'(busy), 0);
                check({name, " valid after done"}, int'(res_valid), 0);
                res_ready = 1'b0;
                tdc_valid = 1'b0;
                tick();
                check({name, " done one cycle"}, int'(done), 0);
                ended = 1;
            end else begin
                check({name, " busy"}, int'(busy), int'(c >= 3));
                check({name, " done low"}, int'(done), 0);
                check({name, " res_valid"}, int'(res_valid), int'(c >= n + 6));
                if (c == 3) check({name, " overflow cleared"}, int'(overflow), 0);
                if (c == n + 6) check({name, " overflow"}, int'(overflow), int'(exp_ovf));
                if (res_valid && acc < 6) begin
                    check({name, " res_idx"}, int'(res_idx), acc);
                    check({name, " res_data"}, int'(res_data), exp_cnt[acc]);
                end
                start     = (c == 2);
                tdc_valid = 1'b0;
                for (int k = 0; k < ev_t.size(); k++) begin
                    if (c == ev_t[k]) begin
                        tdc_start    = ev_s[k];
                        tdc_end      = ev_e[k];
                        tdc_interval = 7'(ev_i[k]);
                    end
                    if (c == ev_t[k] || c == ev_t[k] + 1) tdc_valid = 1'b1;
                end
                case (rmode)
                    0:       res_ready = 1'b1;
                    1:       res_ready = (c % 2) == 1;
                    default: res_ready = 1'($urandom_range(0, 1));
                endcase
                if (res_valid && res_ready) begin
                    acc++;
                    if (acc == 6) finished = 1;
                end
                tick();
            end
        end
        check({name, " words delivered"}, acc, 6);
        check({name, " run ended"}, int'(ended), 1);
        start     = 1'b0;
        tdc_valid = 1'b0;
        res_ready = 1'b0;
        tick();
    endtask

    initial begin
        int nev;
        int lo_r, hi_r, n_r;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        tdc_valid    = 1'b0;
        res_ready    = 1'b0;
        window_len   = '0;
        interval_lo  = '0;
        interval_hi  = 7'd127;
        tdc_start    = '0;
        tdc_end      = '0;
        tdc_interval = '0;
        tick(); tick();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset res_valid", int'(res_valid), 0);
        check("reset res_idx", int'(res_idx), 0);
        check("reset res_data", int'(res_data), 0);
        check("reset overflow", int'(overflow), 0);
        rst_n = 1'b1;
        tick(); tick();

        // Empty window, host always ready
        clear_events();
        do_run("empty", 100, 0, 127, 0);

        // One of each class with the filter wide open
        clear_events();
        add_ev(4, 2'b00, 2'b11, 0);
        add_ev(8, 2'b10, 2'b01, 5);
        add_ev(12, 2'b01, 2'b01, 20);
        add_ev(16, 2'b11, 2'b10, 3);
        do_run("mixed", 40, 0, 127, 0);

        // Interval filter inclusive bounds
        clear_events();
        add_ev(4, 2'b10, 2'b10, 9);
        add_ev(8, 2'b10, 2'b10, 10);
        add_ev(12, 2'b10, 2'b10, 20);
        add_ev(16, 2'b10, 2'b10, 21);
        do_run("filter", 40, 10, 20, 0);

        // Back-to-back events driving a counter into saturation
        clear_events();
        for (int k = 0; k < 17; k++) add_ev(4 + 4 * k, 2'b10, 2'b10, 50);
        do_run("saturate", 80, 0, 127, 0);

        // Next start clears overflow; host ready toggling
        clear_events();
        add_ev(4, 2'b01, 2'b10, 7);
        add_ev(8, 2'b00, 2'b11, 99);
        do_run("toggle", 20, 0, 127, 1);

        // First- and last-RUN-cycle edges counted
        clear_events();
        add_ev(1, 2'b10, 2'b01, 5);
        add_ev(10, 2'b01, 2'b01, 5);
        do_run("run edges", 10, 0, 127, 0);

        // Edge on the start cycle and in the first DRAIN cycle are not counted
        clear_events();
        add_ev(0, 2'b10, 2'b01, 5);
        add_ev(11, 2'b01, 2'b01, 5);
        do_run("outside edges", 10, 0, 127, 0);

        // Zero-length window, and an empty interval window rejecting everything
        clear_events();
        add_ev(1, 2'b10, 2'b10, 5);
        do_run("zero window", 0, 0, 127, 0);
        clear_events();
        add_ev(4, 2'b10, 2'b10, 15);
        add_ev(8, 2'b00, 2'b11, 15);
        do_run("lo gt hi", 20, 20, 10, 0);

        // Randomised runs against the model
        for (int r = 0; r < 4; r++) begin
            clear_events();
            n_r  = int'($urandom_range(20, 60));
            lo_r = int'($urandom_range(0, 70));
            hi_r = int'($urandom_range(30, 127));
            nev  = int'($urandom_range(3, 8));
            for (int k = 0; k < nev; k++)
                add_ev(k * 7 + int'($urandom_range(0, 2)), 2'($urandom), 2'($urandom),
                       int'($urandom_range(0, 127)));
            do_run("random", n_r, lo_r, hi_r, 2);
        end

        // Abort mid-RUN: IDLE next cycle, no done
        window_len = WIN_W'(50);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("abort pre busy", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort res_valid", int'(res_valid), 0);
        check("abort done", int'(done), 0);
        for (int k = 0; k < 60; k++) begin
            tick();
            check("abort stays idle", int'(busy | done | res_valid), 0);
        end

        // Asynchronous reset mid-RUN
        window_len = WIN_W'(30);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("async reset busy", int'(busy), 0);
        check("async reset idx", int'(res_idx), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Normal operation after the reset
        clear_events();
        add_ev(4, 2'b01, 2'b10, 3);
        do_run("after reset", 12, 0, 127, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
